char_bank_sequencer: RTL and testbench

CHAR_BANK_SEQUENCER -- requirements
Module: char_bank_sequencer

---
 rtl/char_bank_sequencer_pkg.sv | 21 ++
 rtl/mismatch_accum.sv | 64 ++++++
 rtl/char_bank_sequencer.sv | 172 +++++++++++++++++
 tb/tb_char_bank_sequencer.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_bank_sequencer_pkg.sv
// Shared definitions for char_bank_sequencer: FSM state codes, default sizing
// and the mismatch score width helper.
package char_bank_sequencer_pkg;

  localparam int DEF_NUM_BANKS    = 16;
  localparam int DEF_PIX_PER_CHAR = 1024;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_FILL    = 3'd1;
  localparam state_t ST_PAD     = 3'd2;
  localparam state_t ST_COMPARE = 3'd3;
  localparam state_t ST_DONE    = 3'd4;

  // One extra bit so a bank that mismatches everywhere still fits.
  function automatic int score_width(input int aw);
    return aw + 1;
  endfunction

endpackage

// File: rtl/mismatch_accum.sv
// Aligned XOR mismatch counter: delays the read strobe by the one-cycle RAM
// latency, accumulates ram^rom and emits a one-cycle score per bank.
module mismatch_accum
  import char_bank_sequencer_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic                       clk,
  input  logic                       i_rst_n,
  input  logic                       i_rd_en,
  input  logic                       i_rd_last,
  input  logic [3:0]                 i_rd_idx,
  input  logic                       i_ram_q,
  input  logic                       i_rom_q,
  output logic [score_width(AW)-1:0] o_score,
  output logic                       o_score_valid,
  output logic [3:0]                 o_score_bank
);

  localparam int SW = score_width(AW);

  logic          r_smp_en;
  logic          r_smp_last;
  logic [3:0]    r_smp_idx;
  logic [SW-1:0] r_acc;
  logic [SW-1:0] r_score;
  logic          r_valid;
  logic [3:0]    r_bank;
  logic [SW-1:0] w_sum;

  assign w_sum = r_acc + {{(SW-1){1'b0}}, i_ram_q ^ i_rom_q};

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_smp_en   <= 1'b0;
      r_smp_last <= 1'b0;
      r_smp_idx  <= '0;
      r_acc      <= '0;
      r_score    <= '0;
      r_valid    <= 1'b0;
      r_bank     <= '0;
    end else begin
      r_smp_en   <= i_rd_en;
      r_smp_last <= i_rd_last;
      r_smp_idx  <= i_rd_idx;
      r_valid    <= r_smp_en && r_smp_last;
      // Clearing on the last sample lets the next bank sweep start back to back.
      if (r_smp_en) begin
        if (r_smp_last) begin
          r_score <= w_sum;
          r_bank  <= r_smp_idx;
          r_acc   <= '0;
        end else begin
          r_acc   <= w_sum;
        end
      end
    end
  end

  assign o_score       = r_score;
  assign o_score_valid = r_valid;
  assign o_score_bank  = r_bank;

endmodule

// File: rtl/char_bank_sequencer.sv
// Fills one-hot character RAM banks from a pixel stream, then sweeps each
// filled bank against a template ROM. Partial-bank padding: CHAR_SEQ_PAD_EN.
module char_bank_sequencer
  import char_bank_sequencer_pkg::*;
#(
  parameter int NUM_BANKS    = DEF_NUM_BANKS,
  parameter int PIX_PER_CHAR = DEF_PIX_PER_CHAR,
  parameter int AW           = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       frame_start,
  input  logic                       pixel_valid,
  input  logic                       pixel_in,
  input  logic                       frame_end,
  input  logic                       ram_q,
  input  logic                       rom_q,
  output logic                       wr_en,
  output logic [NUM_BANKS-1:0]       wr_bank,
  output logic [AW-1:0]              wr_addr,
  output logic                       wr_data,
  output logic [NUM_BANKS-1:0]       rd_bank,
  output logic [AW-1:0]              rd_addr,
  output logic [score_width(AW)-1:0] score,
  output logic                       score_valid,
  output logic [3:0]                 score_bank,
  output logic                       busy,
  output logic                       done,
  output logic [4:0]                 char_count,
  output logic                       overrun
);

  localparam logic [AW-1:0] LAST_ADDR  = AW'(PIX_PER_CHAR - 1);
  localparam logic [4:0]    FULL_COUNT = 5'(NUM_BANKS);

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_BANKS-1:0] r_wr_bank;
  logic [AW-1:0]        r_wr_addr;
  logic [4:0]           r_char_count;
  logic [AW-1:0]        r_rd_addr;
  logic [3:0]           r_rd_idx;
  logic                 r_rd_done;
  logic                 r_overrun;

  logic                 w_fill_wr;
  logic                 w_pad_wr;
  logic                 w_wr_en;
  logic                 w_wr_last;
  logic [AW-1:0]        w_wr_addr_next;
  logic [4:0]           w_count_next;
  logic                 w_rd_en;
  logic                 w_rd_last;
  logic                 w_rd_final;
  logic                 w_score_valid;

  assign w_fill_wr = (r_state == ST_FILL) && pixel_valid;
`ifdef CHAR_SEQ_PAD_EN
  assign w_pad_wr  = (r_state == ST_PAD);
`else
  assign w_pad_wr  = 1'b0;
`endif
  assign w_wr_en        = w_fill_wr || w_pad_wr;
  assign w_wr_last      = w_wr_en && (r_wr_addr == LAST_ADDR);
  assign w_wr_addr_next = w_wr_last ? '0 : (w_wr_en ? r_wr_addr + AW'(1) : r_wr_addr);
  assign w_count_next   = r_char_count + {4'd0, w_wr_last};

  assign w_rd_en    = (r_state == ST_COMPARE) && !r_rd_done && (r_char_count != 5'd0);
  assign w_rd_last  = w_rd_en && (r_rd_addr == LAST_ADDR);
  assign w_rd_final = w_rd_last && ({1'b0, r_rd_idx} == r_char_count - 5'd1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (frame_start) w_state_next = ST_FILL;
      ST_FILL: begin
        if (w_count_next == FULL_COUNT) begin
          w_state_next = ST_COMPARE;
        end else if (frame_end) begin
`ifdef CHAR_SEQ_PAD_EN
          w_state_next = (w_wr_addr_next == '0) ? ST_COMPARE : ST_PAD;
`else
          // A partially filled bank is simply never counted.
          w_state_next = ST_COMPARE;
`endif
        end
      end
`ifdef CHAR_SEQ_PAD_EN
      ST_PAD: if (w_wr_last) w_state_next = ST_COMPARE;
`endif
      ST_COMPARE: begin
        if ((r_char_count == 5'd0) || (w_score_valid && r_rd_done)) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_wr_bank    <= '0;
      r_wr_addr    <= '0;
      r_char_count <= '0;
      r_rd_addr    <= '0;
      r_rd_idx     <= '0;
      r_rd_done    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_IDLE) && frame_start) begin
        r_wr_bank    <= NUM_BANKS'(1);
        r_wr_addr    <= '0;
        r_char_count <= '0;
        r_rd_addr    <= '0;
        r_rd_idx     <= '0;
        r_rd_done    <= 1'b0;
      end else begin
        r_wr_addr <= w_wr_addr_next;
        if (w_wr_last) begin
          r_wr_bank    <= {r_wr_bank[NUM_BANKS-2:0], r_wr_bank[NUM_BANKS-1]};
          r_char_count <= w_count_next;
        end
        if (w_rd_en) begin
          if (w_rd_last) begin
            r_rd_addr <= '0;
            r_rd_idx  <= r_rd_idx + 4'd1;
            if (w_rd_final) r_rd_done <= 1'b1;
          end else begin
            r_rd_addr <= r_rd_addr + AW'(1);
          end
        end
      end
      if (pixel_valid && ((r_state == ST_FILL) || (r_state == ST_COMPARE)) &&
          (r_char_count == FULL_COUNT)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  mismatch_accum #(.AW(AW)) u_accum (
    .clk           (clk),
    .i_rst_n       (reset),
    .i_rd_en       (w_rd_en),
    .i_rd_last     (w_rd_last),
    .i_rd_idx      (r_rd_idx),
    .i_ram_q       (ram_q),
    .i_rom_q       (rom_q),
    .o_score       (score),
    .o_score_valid (w_score_valid),
    .o_score_bank  (score_bank)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_rd_bank
      assign rd_bank[gi] = w_rd_en && (r_rd_idx == 4'(gi));
    end
  endgenerate

  assign wr_en       = w_wr_en;
  assign wr_bank     = r_wr_bank;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = w_fill_wr && pixel_in;
  assign rd_addr     = r_rd_addr;
  assign score_valid = w_score_valid;
  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign char_count  = r_char_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_char_bank_sequencer.sv
// Scoreboard bench for char_bank_sequencer (default sizing); expectations for
// partial frames follow CHAR_SEQ_PAD_EN when it is defined.
module tb_char_bank_sequencer;

  localparam int NB  = 16;
  localparam int PIX = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic        pixel_in = 1'b0;
  logic        frame_end = 1'b0;
  logic        ram_q = 1'b0;
  logic        rom_q = 1'b0;
  logic        wr_en;
  logic [15:0] wr_bank;
  logic [15:0] wr_addr;
  logic        wr_data;
  logic [15:0] rd_bank;
  logic [15:0] rd_addr;
  logic [16:0] score;
  logic        score_valid;
  logic [3:0]  score_bank;
  logic        busy;
  logic        done;
  logic [4:0]  char_count;
  logic        overrun;

  char_bank_sequencer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .pixel_in(pixel_in), .frame_end(frame_end), .ram_q(ram_q), .rom_q(rom_q),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .score(score), .score_valid(score_valid),
    .score_bank(score_bank), .busy(busy), .done(done), .char_count(char_count),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [15:0] bank; logic [15:0] addr; logic data;} wr_t;
  typedef struct packed {logic [3:0] bank; logic [16:0] score;} sc_t;

  wr_t exp_wr_q[$];
  sc_t exp_sc_q[$];
  bit  exp_mem [NB][PIX];
  bit  ram [NB][PIX];
  int  checks = 0;
  int  errors = 0;
  int  n_done = 0;
  int  n_score = 0;

  function automatic bit tmpl(input int b, input int a);
    return bit'((a ^ (a >> 3) ^ b) & 1);
  endfunction

  function automatic bit pix_val(input int b, input int a, input int fb, input int nflip);
    bit flip;
    flip = (b == fb) && (a % 128 == 5) && (a / 128 < nflip);
    return tmpl(b, a) ^ flip;
  endfunction

  // External bank RAM and template ROM, one-cycle read latency.
  always @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < NB; i++) if (wr_bank[i]) ram[i][wr_addr[9:0]] <= wr_data;
    end
    ram_q <= 1'b0;
    rom_q <= 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (rd_bank[i]) begin
        ram_q <= ram[i][rd_addr[9:0]];
        rom_q <= tmpl(i, int'(rd_addr));
      end
    end
  end

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    wr_t ew;
    sc_t es;
    if (reset) begin
      if (wr_en) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write bank=%h addr=%0d data=%0d", wr_bank, wr_addr, wr_data);
        end else begin
          ew = exp_wr_q.pop_front();
          if ({wr_bank, wr_addr, wr_data} !== {ew.bank, ew.addr, ew.data}) begin
            errors++;
            $display("FAIL write got bank=%h addr=%0d data=%0d expected bank=%h addr=%0d data=%0d",
                     wr_bank, wr_addr, wr_data, ew.bank, ew.addr, ew.data);
          end
        end
      end
      if (score_valid) begin
        n_score++;
        checks++;
        $display("score bank=%0d value=%0d", score_bank, score);
        if (exp_sc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_score bank=%0d score=%0d", score_bank, score);
        end else begin
          es = exp_sc_q.pop_front();
          if ({score_bank, score} !== {es.bank, es.score}) begin
            errors++;
            $display("FAIL score got bank=%0d score=%0d expected bank=%0d score=%0d",
                     score_bank, score, es.bank, es.score);
          end
        end
      end
      if (done) n_done++;
      if (!busy) begin
        checks++;
        if (rd_bank !== 16'h0) begin
          errors++;
          $display("FAIL rd_bank_idle got %h expected 0000", rd_bank);
        end
      end
    end
  end

  task automatic drive_frame(input int npix, input int fb, input int nflip,
                             input bit coincident, input int exp_count);
    int  b, a, s, nfull, rem;
    wr_t e;
    sc_t es;
    nfull = npix / PIX;
    rem   = npix % PIX;
    for (int k = 0; k < npix && k < NB * PIX; k++) begin
      b = k / PIX;
      a = k % PIX;
      exp_mem[b][a] = pix_val(b, a, fb, nflip);
      e.bank = 16'd1 << b;
      e.addr = 16'(a);
      e.data = exp_mem[b][a];
      exp_wr_q.push_back(e);
    end
`ifdef CHAR_SEQ_PAD_EN
    if (rem != 0 && nfull < NB) begin
      for (int p = rem; p < PIX; p++) begin
        exp_mem[nfull][p] = 1'b0;
        e.bank = 16'd1 << nfull;
        e.addr = 16'(p);
        e.data = 1'b0;
        exp_wr_q.push_back(e);
      end
    end
`endif
    for (int bb = 0; bb < exp_count; bb++) begin
      s = 0;
      for (int p = 0; p < PIX; p++) s += int'(exp_mem[bb][p] ^ tmpl(bb, p));
      es.bank  = 4'(bb);
      es.score = 17'(s);
      exp_sc_q.push_back(es);
    end
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int k = 0; k < npix; k++) begin
      pixel_valid = 1'b1;
      pixel_in    = pix_val(k / PIX, k % PIX, fb, nflip);
      frame_end   = coincident && (k == npix - 1);
      @(posedge clk); #1;
    end
    pixel_valid = 1'b0;
    pixel_in    = 1'b0;
    frame_end   = 1'b0;
    if (!coincident) begin
      frame_end = 1'b1;
      @(posedge clk); #1;
      frame_end = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input int npix, input int fb, input int nflip,
                           input bit coincident, input int exp_count, input bit exp_ovr,
                           input logic [15:0] exp_wr_bank);
    int d0, s0;
    d0 = n_done;
    s0 = n_score;
    drive_frame(npix, fb, nflip, coincident, exp_count);
    for (int c = 0; c < 20000 && n_done == d0; c++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (n_done == d0) begin
      errors++;
      $display("FAIL %s_done_timeout got no done expected one", name);
    end
    checks++;
    if (char_count !== 5'(exp_count)) begin
      errors++;
      $display("FAIL %s_char_count got %0d expected %0d", name, char_count, exp_count);
    end
    checks++;
    if (overrun !== exp_ovr) begin
      errors++;
      $display("FAIL %s_overrun got %0d expected %0d", name, overrun, exp_ovr);
    end
    checks++;
    if (n_score - s0 != exp_count) begin
      errors++;
      $display("FAIL %s_score_pulses got %0d expected %0d", name, n_score - s0, exp_count);
    end
    checks++;
    if (wr_bank !== exp_wr_bank) begin
      errors++;
      $display("FAIL %s_wr_bank got %h expected %h", name, wr_bank, exp_wr_bank);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got busy=%0d done=%0d expected 0 0", name, busy, done);
    end
    checks++;
    if (exp_wr_q.size() != 0 || exp_sc_q.size() != 0) begin
      errors++;
      $display("FAIL %s_leftover got writes=%0d scores=%0d expected 0 0",
               name, exp_wr_q.size(), exp_sc_q.size());
    end
    $display("frame %s count=%0d overrun=%0d", name, char_count, overrun);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wr_en, wr_bank, wr_addr, wr_data, rd_bank, rd_addr, score, score_valid, score_bank,
         busy, done, char_count, overrun} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero expected all zero (busy=%0d wr_bank=%h)", busy, wr_bank);
    end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || wr_bank !== 16'h0) begin
      errors++;
      $display("FAIL reset_release got busy=%0d wr_bank=%h expected 0 0000", busy, wr_bank);
    end
  endtask

  task automatic test_two_banks();
    run_frame("two_banks", 2 * PIX, 0, 3, 1'b1, 2, 1'b0, 16'h0004);
  endtask

  task automatic test_mismatch();
    run_frame("mismatch", 2 * PIX, 1, 5, 1'b0, 2, 1'b0, 16'h0004);
  endtask

  task automatic test_partial();
`ifdef CHAR_SEQ_PAD_EN
    run_frame("partial", 1500, 0, 2, 1'b0, 2, 1'b0, 16'h0004);
`else
    run_frame("partial", 1500, 0, 2, 1'b0, 1, 1'b0, 16'h0002);
`endif
  endtask

  task automatic test_overrun();
    run_frame("overrun", NB * PIX + 3, 15, 7, 1'b0, 16, 1'b1, 16'h0001);
  endtask

  task automatic test_empty_frame();
    int s0, d0;
    s0 = n_score;
    d0 = n_done;
    @(posedge clk); #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    frame_end   = 1'b1;
    @(posedge clk); #1;
    frame_end   = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL empty_compare got busy=%0d done=%0d expected 1 0", busy, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL empty_done got %0d expected 1", done);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || char_count !== 5'd0) begin
      errors++;
      $display("FAIL empty_idle got busy=%0d done=%0d count=%0d expected 0 0 0", busy, done, char_count);
    end
    checks++;
    if (n_score != s0 || n_done != d0 + 1) begin
      errors++;
      $display("FAIL empty_pulses got scores=%0d dones=%0d expected 0 1", n_score - s0, n_done - d0);
    end
    $display("frame empty count=%0d", char_count);
  endtask

  task automatic test_reset_mid_compare();
    int s0, d0;
    drive_frame(PIX, 0, 4, 1'b1, 1);
    repeat (200) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || rd_bank !== 16'h0001) begin
      errors++;
      $display("FAIL midcmp_active got busy=%0d rd_bank=%h expected 1 0001", busy, rd_bank);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_bank, wr_addr, wr_data, rd_bank, rd_addr, score, score_valid, score_bank,
         busy, done, char_count, overrun} !== '0) begin
      errors++;
      $display("FAIL midcmp_async_reset got busy=%0d rd_bank=%h rd_addr=%0d count=%0d expected all zero",
               busy, rd_bank, rd_addr, char_count);
    end
    exp_sc_q.delete();
    exp_wr_q.delete();
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    s0 = n_score;
    d0 = n_done;
    repeat (1200) @(posedge clk);
    #1;
    checks++;
    if (n_score != s0 || n_done != d0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midcmp_abandon got scores=%0d dones=%0d busy=%0d expected 0 0 0",
               n_score - s0, n_done - d0, busy);
    end
    $display("frame reset_mid_compare busy=%0d", busy);
  endtask

  initial begin
    test_reset();
    test_two_banks();
    test_mismatch();
    test_partial();
    test_empty_frame();
    test_overrun();
    test_reset_mid_compare();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
